// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared state type, default widths and counter-width helper for seq_div
package seq_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int NW_DEF = 33;
  localparam int DW_DEF = 16;
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seq_div_sign.sv
// seq_div_sign: conditional two's-complement (abs when neg = msb, apply sign otherwise)
//   a   : input value or magnitude
//   neg : negate when high
//   y   : neg ? -a : a
module seq_div_sign #(parameter int W = 16) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? -a : a;
endmodule

// File: rtl/seq_div.sv
// seq_div: sequential signed radix-2 restoring divider with start/busy/done handshake
//   clk, rst (async, active high), ce (global freeze), start
//   nin [NW] signed dividend, din [DW] signed divisor
//   busy, done (one ce-cycle pulse), qout [QW] quotient, rout [DW] remainder, dz, ovf
//   SEQ_DIV_ROUND_EN: round quotient to nearest, half away from zero
module seq_div
  import seq_div_pkg::*;
#(
  parameter  int NW = NW_DEF,
  parameter  int DW = DW_DEF,
  localparam int QW = NW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          start,
  input  logic [NW-1:0] nin,
  input  logic [DW-1:0] din,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] qout,
  output logic [DW-1:0] rout,
  output logic          dz,
  output logic          ovf
);
  localparam int CW = cnt_w(NW);
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [NW-1:0] n_q, n_abs, n_d, q_s, qsat;
  logic [DW-1:0] r_q, d_q, d_abs, r_d, rm, r_s;
  logic          sn_q, sq_q, dzp_q, busy_q, done_q, dz_q, ovf_q;
  logic [QW-1:0] qout_q;
  logic [DW-1:0] rout_q;
  logic [DW:0]   sh;
  logic          ge, ovf_d;
  logic [NW:0]   qm, lim;
  seq_div_sign #(.W(NW)) u_nabs (.a(nin), .neg(nin[NW-1]), .y(n_abs));
  seq_div_sign #(.W(DW)) u_dabs (.a(din), .neg(din[DW-1]), .y(d_abs));
  seq_div_sign #(.W(NW)) u_qsgn (.a(qm[NW-1:0]), .neg(sq_q), .y(q_s));
  seq_div_sign #(.W(DW)) u_rsgn (.a(rm), .neg(sn_q), .y(r_s));
  // n_q doubles as dividend shifter and quotient collector; the difference always fits DW bits
  always_comb begin
    sh  = {r_q, n_q[NW-1]};
    ge  = sh >= {1'b0, d_q};
    r_d = ge ? sh[DW-1:0] - d_q : sh[DW-1:0];
    n_d = {n_q[NW-2:0], ge};
  end
`ifdef SEQ_DIV_ROUND_EN
  logic rnd;
  assign rnd = {r_q, 1'b0} >= {1'b0, d_q};
  // rounding up leaves a remainder of opposite sign to the dividend, so rm is modular
  assign qm  = {1'b0, n_q} + {{NW{1'b0}}, rnd};
  assign rm  = rnd ? r_q - d_q : r_q;
`else
  assign qm  = {1'b0, n_q};
  assign rm  = r_q;
`endif
  // a negative quotient may reach magnitude 2^(NW-1), a positive one only 2^(NW-1)-1
  assign lim   = {2'b01, {(NW-1){1'b0}}} - {{NW{1'b0}}, !sq_q};
  assign ovf_d = qm > lim;
  assign qsat  = sq_q ? {1'b1, {(NW-1){1'b0}}} : {1'b0, {(NW-1){1'b1}}};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      sn_q    <= 1'b0;
      sq_q    <= 1'b0;
      dzp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      qout_q  <= '0;
      rout_q  <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (ce) begin
      unique case (state_q)
        IDLE: if (start) begin
          n_q     <= n_abs;
          d_q     <= d_abs;
          r_q     <= '0;
          sn_q    <= nin[NW-1];
          sq_q    <= nin[NW-1] ^ din[DW-1];
          dzp_q   <= din == '0;
          dz_q    <= 1'b0;
          ovf_q   <= 1'b0;
          cnt_q   <= CW'(NW - 1);
          busy_q  <= 1'b1;
          state_q <= (din == '0) ? FIX : CALC;
        end
        CALC: begin
          r_q     <= r_d;
          n_q     <= n_d;
          cnt_q   <= cnt_q - 1'b1;
          state_q <= (cnt_q == '0) ? FIX : CALC;
        end
        FIX: begin
          dz_q    <= dzp_q;
          ovf_q   <= !dzp_q && ovf_d;
          qout_q  <= dzp_q ? '0 : ovf_d ? qsat : q_s;
          rout_q  <= (dzp_q || ovf_d) ? '0 : r_s;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        // first DONE cycle raises the pulse, second drops it and returns to IDLE
        DONE: begin
          done_q  <= !done_q;
          state_q <= done_q ? IDLE : DONE;
        end
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign qout = qout_q;
  assign rout = rout_q;
  assign dz   = dz_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed self-checking bench for seq_div
module tb_seq_div;
  logic        clk = 0, rst = 0, ce = 1, start = 0;
  logic [32:0] nin = '0;
  logic [15:0] din = '0;
  logic        busy, done, dz, ovf;
  logic [32:0] qout;
  logic [15:0] rout;
  int          checks = 0, failures = 0, lat = 0, seen = 0;
  seq_div dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .nin(nin), .din(din),
    .busy(busy), .done(done), .qout(qout), .rout(rout), .dz(dz), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic kick(input logic [32:0] n, input logic [15:0] d);
    @(negedge clk);
    nin = n;
    din = d;
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic run(input logic [32:0] n, input logic [15:0] d, input int ce_off, output int cyc);
    kick(n, d);
    cyc = 0;
    chk("busy_rise", busy, 1);
    while (!done && cyc < 200) begin
      if (ce_off > 0 && cyc == ce_off) ce = 0;
      if (ce_off > 0 && cyc == ce_off + 5) ce = 1;
      if (ce_off > 0 && cyc == ce_off + 10) begin
        start = 1;
        nin = 33'd9;
        din = 16'd3;
      end
      if (ce_off > 0 && cyc == ce_off + 11) start = 0;
      @(posedge clk);
      #1 cyc++;
    end
  endtask
  task automatic result(input string tag, input int cyc, input int exp_lat, input logic [32:0] q,
                        input logic [15:0] r, input logic z, input logic o);
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_qout"}, qout, q);
    chk({tag, "_rout"}, rout, r);
    chk({tag, "_dz"}, dz, z);
    chk({tag, "_ovf"}, ovf, o);
    chk({tag, "_busy_at_done"}, busy, 0);
    @(posedge clk);
    #1 chk({tag, "_done_pulse_end"}, done, 0);
  endtask
  initial begin
    #2 rst = 1;
    #10;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_qout", qout, 0);
    chk("reset_rout", rout, 0);
    chk("reset_flags", {dz, ovf}, 0);
    @(negedge clk) rst = 0;
    run(33'd100, 16'd7, 0, lat);
    result("p100_p7", lat, 35, 33'd14, 16'd2, 0, 0);
    run(-33'd100, 16'd7, 0, lat);
    result("n100_p7", lat, 35, -33'd14, -16'd2, 0, 0);
    run(33'd100, -16'd7, 0, lat);
    result("p100_n7", lat, 35, -33'd14, 16'd2, 0, 0);
    run(-33'd100, -16'd7, 0, lat);
    result("n100_n7", lat, 35, 33'd14, -16'd2, 0, 0);
    run(33'd7, 16'd0, 0, lat);
    result("div_zero", lat, 2, 33'd0, 16'd0, 1, 0);
    run(33'h1_0000_0000, 16'hFFFF, 0, lat);
    result("overflow", lat, 35, 33'h0_FFFF_FFFF, 16'd0, 0, 1);
    run(33'd100, 16'd7, 10, lat);
    result("ce_gap", lat, 40, 33'd14, 16'd2, 0, 0);
    repeat (3) @(posedge clk);
    #1 chk("hold_qout", qout, 33'd14);
    @(negedge clk);
    ce = 0;
    start = 1;
    nin = 33'd9;
    din = 16'd3;
    repeat (3) @(negedge clk);
    start = 0;
    ce = 1;
    @(negedge clk);
    chk("ce_low_start_ignored", busy, 0);
    chk("ce_low_hold_rout", rout, 16'd2);
    kick(33'd100, 16'd7);
    repeat (10) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk) rst = 0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    run(33'd9, 16'd3, 0, lat);
    result("after_rst_9_3", lat, 35, 33'd3, 16'd0, 0, 0);
`ifdef SEQ_DIV_ROUND_EN
    run(33'd11, 16'd2, 0, lat);
    result("p11_p2", lat, 35, 33'd6, -16'd1, 0, 0);
    run(-33'd11, 16'd2, 0, lat);
    result("n11_p2", lat, 35, -33'd6, 16'd1, 0, 0);
`else
    run(33'd11, 16'd2, 0, lat);
    result("p11_p2", lat, 35, 33'd5, 16'd1, 0, 0);
    run(-33'd11, 16'd2, 0, lat);
    result("n11_p2", lat, 35, -33'd5, -16'd1, 0, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
Sequential signed radix-2 restoring divider. It is the inverse companion of the pre-add multiplier: it takes a full-width product-style dividend and a coefficient-width divisor, and returns quotient and remainder. Used wherever a pre-add-multiply result must be scaled back, for example to recover (a+d) from p and b. One division is in flight at a time, under a start/busy/done handshake.

Parameters:
- NW, 33, dividend width in bits (matches AW+1+BW of the multiplier with 16/16 operands).
- DW, 16, divisor width in bits.
- QW, NW, quotient width in bits (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; when low the whole block freezes.
- start  in  1  request a division; sampled only in IDLE with ce=1.
- nin  in  NW  signed dividend.
- din  in  DW  signed divisor.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle (ce-qualified) result-valid pulse.
- qout  out  QW  signed quotient.
- rout  out  DW  signed remainder.
- dz  out  1  divide-by-zero flag for the current result.
- ovf  out  1  quotient-overflow flag for the current result.

Behaviour:
- Reset: async assert of rst forces state=IDLE; busy, done, qout, rout, dz, ovf all 0; iteration counter 0.
- Reset mid-operation: the division is abandoned and no done is issued. The next start after rst deasserts is accepted normally.
- ce=0: all registers hold, including done, counter and state. start is ignored while ce=0. Latency in cycles extends by the number of ce-low cycles.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start&ce, capture |nin|, |din|, sign_n, sign_q = sign_n^sign_d.
  - Clear dz/ovf. Counter = NW-1.
  - If din==0, go to FIX with dz pending; otherwise go to CALC.
  - busy rises on the cycle after acceptance.
- CALC: one quotient bit per ce cycle, MSB first.
  - Shift the partial remainder left, bring in the next dividend bit.
  - Trial-subtract |d| at width DW+1. If non-negative, keep the difference and set q bit=1.
  - Counter decrements; after NW iterations go to FIX.
- FIX:
  - Apply signs: q = sign_q ? -|q| : |q|; r = sign_n ? -|r| : |r|. Truncation is toward zero; the remainder takes the dividend's sign.
  - Overflow: nin = -2^(NW-1) with din = -1 gives ovf=1 and qout = 2^(NW-1)-1 (saturated), rout=0.
  - Divide by zero: dz=1, qout=0, rout=0.
  - Register the outputs and go to DONE.
- DONE: done=1 and busy=0 for one ce cycle, then IDLE. start is not accepted in DONE.
- Latency:
  - Normal division: start accepted at edge k gives done high after edge k+NW+2 (NW CALC + FIX + DONE entry).
  - Divide by zero: done high after edge k+2.
- Hold: qout/rout/dz/ovf hold after done until the next start is accepted.
- start while busy or in DONE: ignored, with no queuing.

Optional Feature:
Macro SEQ_DIV_ROUND_EN.
- Defined: FIX rounds the quotient to nearest, half away from zero.
  - If 2|r| >= |d|, then |q|+=1 and |r| -= |d|, before signs are applied.
  - Latency is unchanged.
  - ovf is also set if the rounded magnitude exceeds 2^(QW-1)-1; qout then saturates.
- Undefined: truncation toward zero as above; the rounding logic is absent.

Decomposition:
- Package seq_div_pkg: state enum type (IDLE, CALC, FIX, DONE), default width constants NW_DEF=33 and DW_DEF=16, and a localparam-style function for counter width $clog2(NW).
- One sub-module, seq_div_sign: combinational abs/negate helper (magnitude and sign split on input, conditional two's-complement on output), instantiated for dividend, divisor, quotient and remainder.
- The FSM and datapath stay in seq_div.

Test Plan:
- Basic positive division: rst pulse, then start with nin=100, din=7 -> done at accept+35 cycles; qout=14, rout=2, dz=0, ovf=0.
- Sign combinations: nin=-100, din=7 -> qout=-14, rout=-2. nin=100, din=-7 -> qout=-14, rout=2. nin=-100, din=-7 -> qout=14, rout=-2.
- Divide by zero and overflow:
  - nin=7, din=0 -> done at accept+2; dz=1, qout=0, rout=0.
  - nin=-2^32, din=-1 -> ovf=1, qout=2^32-1.
- ce and start gating: hold ce low for 5 cycles mid-CALC on 100/7 -> done at accept+40 with the same result. A start pulse while busy is ignored, and the outputs are unchanged.
- Reset mid-operation: assert rst 10 cycles into a division -> busy=0 immediately and no done. A fresh start of 9/3 then gives qout=3, rout=0.
- With SEQ_DIV_ROUND_EN: 11/2 -> qout=6, rout=-1. -11/2 -> qout=-6, rout=1. 100/7 -> qout=14, rout=2.
